lsu_axil_master: RTL and testbench

LSU_AXIL_MASTER -- requirements
Module: lsu_axil_master

---
 rtl/lsu_axil_master_pkg.sv | 23 ++
 rtl/lsu_axil_master.sv | 192 +++++++++++++++++++
 tb/tb_lsu_axil_master.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_axil_master_pkg.sv
// Shared AXI-lite definitions for the LSU master.
// Holds the bus widths, the AXI response codes and the LSU FSM state encoding.
package lsu_axil_master_pkg;

    // AXI-lite bus widths used as parameter defaults.
    localparam int unsigned AXI_ADDR_BUS = 32;
    localparam int unsigned AXI_DATA_BUS = 32;

    // AXI response codes.
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // LSU transaction FSM; the unused 3-bit codes are recovered to S_IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4,
        S_RSP   = 3'd5
    } lsu_state_e;

endpackage

// File: rtl/lsu_axil_master.sv
// Single-outstanding load/store unit bridging a core request/response port to
// an AXI-lite master.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_*                      core request (valid/ready, we, addr, wdata, wstrb)
//   rsp_*                      core response (valid/ready, rdata, err)
//   ar*/r*/aw*/w*/b*           AXI-lite master channels
module lsu_axil_master
    import lsu_axil_master_pkg::*;
#(
    parameter int unsigned ADDR_W = AXI_ADDR_BUS,
    parameter int unsigned DATA_W = AXI_DATA_BUS
) (
    input  logic                clk,
    input  logic                rst_n,
    // core request
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    // core response
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    // AR channel
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    // R channel
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    // AW channel
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    // W channel
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    // B channel
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int unsigned STRB_W = DATA_W / 8;

    lsu_state_e          state_q,     state_d;
    logic [ADDR_W-1:0]   araddr_q,    araddr_d;
    logic [ADDR_W-1:0]   awaddr_q,    awaddr_d;
    logic [DATA_W-1:0]   wdata_q,     wdata_d;
    logic [STRB_W-1:0]   wstrb_q,     wstrb_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic                aw_done_q,   aw_done_d;
    logic                w_done_q,    w_done_d;

    // AW/W handshakes seen this cycle; each channel completes only once.
    logic aw_hs, w_hs;
    assign aw_hs = (state_q == S_WREQ) && !aw_done_q && awready;
    assign w_hs  = (state_q == S_WREQ) && !w_done_q  && wready;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            araddr_q    <= '0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            araddr_q    <= araddr_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    // Next-state and capture logic.
    always_comb begin
        state_d     = state_q;
        araddr_d    = araddr_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_we) begin
                        awaddr_d  = req_addr;
                        wdata_d   = req_wdata;
                        wstrb_d   = req_wstrb;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = S_WREQ;
                    end else begin
                        araddr_d  = req_addr;
                        state_d   = S_RADDR;
                    end
                end
            end
            S_RADDR: begin
                if (arready) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    rsp_rdata_d = rdata;
                    rsp_err_d   = (rresp != AXI_RESP_OKAY);
                    state_d     = S_RSP;
                end
            end
            S_WREQ: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q  | w_hs;
                // Both channels may finish in the same cycle.
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = (bresp != AXI_RESP_OKAY);
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from the registered state and done flags.
    always_comb begin
        req_ready = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE:  req_ready = 1'b1;
            S_RADDR: arvalid   = 1'b1;
            S_RDATA: rready    = 1'b1;
            S_WREQ: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
            end
            S_WRESP: bready    = 1'b1;
            S_RSP:   rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    assign araddr    = araddr_q;
    assign awaddr    = awaddr_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_axil_master.sv
// Scoreboard bench for lsu_axil_master: directed requests push expected
// responses, a monitor pops them on each response handshake, and small
// slave models check channel timing and payload stability.
module tb_lsu_axil_master;
    import lsu_axil_master_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              e;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                req_valid, req_ready, req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [DATA_W/8-1:0] req_wstrb;
    logic                rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [ADDR_W-1:0]   araddr, awaddr;
    logic                arvalid, arready, rvalid, rready;
    logic [DATA_W-1:0]   rdata, wdata;
    logic [1:0]          rresp, bresp;
    logic                awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DATA_W/8-1:0] wstrb;

    // Slave configuration and expected payloads, set by the stimulus.
    int                  ar_wait, r_delay, aw_wait, w_wait, b_delay;
    logic [DATA_W-1:0]   cfg_rdata;
    logic [1:0]          cfg_rresp, cfg_bresp;
    logic [ADDR_W-1:0]   exp_araddr, exp_awaddr;
    logic [DATA_W-1:0]   exp_wdata;
    logic [DATA_W/8-1:0] exp_wstrb;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   acc_cyc;

    lsu_axil_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endfunction

    // Response monitor: sampled just after the falling edge so rsp_ready is settled.
    initial forever begin
        @(negedge clk);
        #1;
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.d));
                check("rsp_err", 64'(rsp_err), 64'(e.e));
            end
        end
    end

    // AR/R slave.
    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = AXI_RESP_OKAY;
        forever begin
            @(negedge clk);
            if (arvalid) begin
                int errs;
                errs = (araddr !== exp_araddr) ? 1 : 0;
                for (int i = 0; i < ar_wait; i++) begin
                    @(negedge clk);
                    if (!arvalid || araddr !== exp_araddr) errs++;
                end
                check("ar_stable", 64'(errs), 64'd0);
                arready = 1'b1;
                @(negedge clk);
                arready = 1'b0;
                check("arvalid_drop", 64'(arvalid), 64'd0);
                repeat (r_delay) @(negedge clk);
                rvalid = 1'b1; rdata = cfg_rdata; rresp = cfg_rresp;
                @(negedge clk);
                rvalid = 1'b0; rdata = '0; rresp = AXI_RESP_OKAY;
            end
        end
    end

    // AW slave.
    initial begin
        awready = 1'b0;
        forever begin
            @(negedge clk);
            if (awvalid) begin
                int errs;
                errs = (awaddr !== exp_awaddr) ? 1 : 0;
                for (int i = 0; i < aw_wait; i++) begin
                    @(negedge clk);
                    if (!awvalid || awaddr !== exp_awaddr) errs++;
                end
                check("aw_stable", 64'(errs), 64'd0);
                awready = 1'b1;
                @(negedge clk);
                awready = 1'b0;
                check("awvalid_drop", 64'(awvalid), 64'd0);
            end
        end
    end

    // W slave.
    initial begin
        wready = 1'b0;
        forever begin
            @(negedge clk);
            if (wvalid) begin
                int errs;
                errs = (wdata !== exp_wdata || wstrb !== exp_wstrb) ? 1 : 0;
                for (int i = 0; i < w_wait; i++) begin
                    @(negedge clk);
                    if (!wvalid || wdata !== exp_wdata || wstrb !== exp_wstrb) errs++;
                end
                check("w_stable", 64'(errs), 64'd0);
                wready = 1'b1;
                @(negedge clk);
                wready = 1'b0;
                check("wvalid_drop", 64'(wvalid), 64'd0);
            end
        end
    end

    // B slave.
    initial begin
        bvalid = 1'b0; bresp = AXI_RESP_OKAY;
        forever begin
            @(negedge clk);
            if (bready) begin
                repeat (b_delay) @(negedge clk);
                bvalid = 1'b1; bresp = cfg_bresp;
                @(negedge clk);
                bvalid = 1'b0; bresp = AXI_RESP_OKAY;
            end
        end
    end

    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, input logic [DATA_W/8-1:0] ws);
        int n;
        n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", 64'(req_ready), 64'd1);
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int exp_lat);
        int n;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 64'd0, 64'd1);
        end else begin
            check("rsp_latency", 64'(cyc - acc_cyc), 64'(exp_lat));
            check("req_ready_in_rsp", 64'(req_ready), 64'd0);
            while (!rsp_ready) @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int errs;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
        ar_wait = 0; r_delay = 0; aw_wait = 0; w_wait = 0; b_delay = 0;
        cfg_rdata = '0; cfg_rresp = AXI_RESP_OKAY; cfg_bresp = AXI_RESP_OKAY;
        exp_araddr = '0; exp_awaddr = '0; exp_wdata = '0; exp_wstrb = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_valids", 64'({arvalid, rready, awvalid, wvalid, bready, rsp_valid}), 64'd0);
        check("rst_regs", 64'(araddr | awaddr | wdata | 32'(wstrb) | rsp_rdata | 32'(rsp_err)), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait read.
        ar_wait = 0; r_delay = 0; cfg_rdata = 32'h0000_0413; cfg_rresp = AXI_RESP_OKAY;
        exp_araddr = 32'h8000_0000;
        sb.push_back('{d: 32'h0000_0413, e: 1'b0});
        do_req(1'b0, 32'h8000_0000, '0, '0);
        wait_rsp(3);

        // Read with arready held low 2 cycles and 3 extra rvalid wait cycles.
        ar_wait = 2; r_delay = 3; cfg_rdata = 32'hCAFE_0001;
        exp_araddr = 32'h1000_0004;
        sb.push_back('{d: 32'hCAFE_0001, e: 1'b0});
        do_req(1'b0, 32'h1000_0004, '0, '0);
        wait_rsp(8);

        // Write with AW accepted in the first cycle and W in the third.
        aw_wait = 0; w_wait = 2; b_delay = 0; cfg_bresp = AXI_RESP_OKAY;
        exp_awaddr = 32'h8000_0010; exp_wdata = 32'hDEAD_BEEF; exp_wstrb = 4'b0011;
        sb.push_back('{d: 32'h0, e: 1'b0});
        do_req(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011);
        wait_rsp(5);
        check("araddr_hold", 64'(araddr), 64'h1000_0004);

        // Write with AW and W accepted together, slave error.
        aw_wait = 0; w_wait = 0; cfg_bresp = AXI_RESP_SLVERR;
        exp_awaddr = 32'h0000_0100; exp_wdata = 32'h1234_5678; exp_wstrb = 4'b1111;
        sb.push_back('{d: 32'h0, e: 1'b1});
        do_req(1'b1, 32'h0000_0100, 32'h1234_5678, 4'b1111);
        wait_rsp(3);

        // Read error response held while the core stalls for 4 cycles.
        ar_wait = 0; r_delay = 0; cfg_rdata = 32'h0000_55AA; cfg_rresp = AXI_RESP_SLVERR;
        exp_araddr = 32'h0000_0200;
        sb.push_back('{d: 32'h0000_55AA, e: 1'b1});
        rsp_ready = 1'b0;
        do_req(1'b0, 32'h0000_0200, '0, '0);
        errs = 0;
        for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
        check("hold_rsp_seen", 64'(rsp_valid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!rsp_valid || req_ready || rsp_rdata !== 32'h0000_55AA || rsp_err !== 1'b1) errs++;
        end
        check("rsp_hold", 64'(errs), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rsp_single", 64'(rsp_valid), 64'd0);

        // Reset while waiting in RDATA aborts the read silently.
        ar_wait = 0; r_delay = 5; cfg_rdata = 32'hBAD0_BAD0; cfg_rresp = AXI_RESP_OKAY;
        exp_araddr = 32'h2000_0000;
        do_req(1'b0, 32'h2000_0000, '0, '0);
        for (int n = 0; n < 20 && !rready; n++) @(negedge clk);
        check("abort_in_rdata", 64'(rready), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valids", 64'({arvalid, rready, awvalid, wvalid, bready, rsp_valid}), 64'd0);
        check("abort_araddr", 64'(araddr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_req_ready", 64'(req_ready), 64'd1);
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid || rready) errs++;
        end
        check("abort_no_rsp", 64'(errs), 64'd0);

        // Normal read after the aborted one.
        ar_wait = 0; r_delay = 0; cfg_rdata = 32'h0000_1234; cfg_rresp = AXI_RESP_OKAY;
        exp_araddr = 32'h8000_0000;
        sb.push_back('{d: 32'h0000_1234, e: 1'b0});
        do_req(1'b0, 32'h8000_0000, '0, '0);
        wait_rsp(3);

        repeat (4) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
